// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready pipeline applying a selectable bitwise logic function
// to x/y/z, with result popcount, parity and a completed-transfer counter.
module logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16,
  localparam int PC_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [PC_W-1:0]  ones,
  output logic             parity,
  output logic [CNT_W-1:0] xfer_count
);

  // Handshake: a transfer happens on any rising edge where valid && ready.
  // in_ready depends on out_ready and stage state only, never on in_valid.

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_INVX = 3'b010,
    OP_INVY = 3'b011,
    OP_XOR  = 3'b100,
    OP_NAND = 3'b101,
    OP_NOR  = 3'b110,
    OP_CIRC = 3'b111
  } op_e;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_data;
  logic             s2_valid;
  logic             s2_free;
  logic             s1_adv;
  logic             in_fire;
  logic [WIDTH-1:0] func;
  logic [PC_W-1:0]  s1_ones;

  assign s2_free   = !s2_valid || out_ready;
  assign s1_adv    = s1_valid && s2_free;
  assign in_ready  = !s1_valid || s2_free;
  assign in_fire   = in_valid && in_ready;
  assign out_valid = s2_valid;

  always_comb begin
    func = '0;
    case (op_e'(op))
      OP_AND:  func = x & y;
      OP_OR:   func = x | y;
      OP_INVX: func = ~x;
      OP_INVY: func = ~y;
      OP_XOR:  func = x ^ y;
      OP_NAND: func = ~(x & y);
      OP_NOR:  func = ~(x | y);
      OP_CIRC: func = (x & y) | ~z;
      default: func = '0;
    endcase
  end

  always_comb begin
    s1_ones = '0;
    for (int i = 0; i < WIDTH; i++) begin
      s1_ones = s1_ones + PC_W'(s1_data[i]);
    end
  end

  // Stage 1: a new input may load in the same cycle the old one advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_data  <= func;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      out      <= '0;
      ones     <= '0;
      parity   <= 1'b0;
    end else if (s1_adv) begin
      s2_valid <= 1'b1;
      out      <= s1_data;
      ones     <= s1_ones;
      parity   <= ^s1_data;
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_count <= '0;
    end else if (s2_valid && out_ready) begin
      xfer_count <= xfer_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe (WIDTH=8, CNT_W=4 so the counter wraps quickly).
module tb_logic_unit_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic [7:0] x, y, z;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out;
  logic [3:0] ones;
  logic       parity;
  logic [3:0] xfer_count;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  logic_unit_pipe #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .x(x), .y(y), .z(z), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .ones(ones), .parity(parity), .xfer_count(xfer_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] model(input logic [2:0] o, input logic [7:0] a,
                                       input logic [7:0] b, input logic [7:0] c);
    case (o)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return ~a;
      3'd3: return ~b;
      3'd4: return a ^ b;
      3'd5: return ~(a & b);
      3'd6: return ~(a | b);
      default: return (a & b) | ~c;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 3'd0; x = '0; y = '0; z = '0;
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    in_valid = 1'b0; out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out !== 8'h00 || ones !== 4'd0 || parity !== 1'b0 ||
        xfer_count !== 4'd0) begin
      errors++;
      $display("FAIL reset_values: got valid=%b out=%h ones=%0d par=%b cnt=%0d, need 0s",
               out_valid, out, ones, parity, xfer_count);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b need 1", in_ready);
    end
  endtask

  task automatic test_basic_and();
    do_reset();
    out_ready = 1'b1;
    op = 3'd0; x = 8'hF0; y = 8'h3C; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL and_early_valid: got %b need 0", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out !== 8'h30 || ones !== 4'd2 || parity !== 1'b0) begin
      errors++;
      $display("FAIL and_result: got valid=%b out=%h ones=%0d par=%b need 1 30 2 0",
               out_valid, out, ones, parity);
    end
    tick();
    checks++;
    if (xfer_count !== 4'd1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL and_count: got cnt=%0d valid=%b need 1 0", xfer_count, out_valid);
    end
  endtask

  task automatic test_op_sweep();
    logic [7:0] exp_out[8];
    logic [3:0] exp_ones[8];
    exp_out  = '{8'h05, 8'hAF, 8'h5A, 8'hF0, 8'hAA, 8'hFA, 8'h50, 8'hCD};
    exp_ones = '{4'd2, 4'd6, 4'd4, 4'd4, 4'd4, 4'd6, 4'd2, 4'd5};
    do_reset();
    out_ready = 1'b1;
    x = 8'hA5; y = 8'h0F; z = 8'h33;
    for (int c = 0; c < 10; c++) begin
      if (c < 8) begin
        op = 3'(c); in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (c >= 1 && c <= 8) begin
        checks++;
        if (out_valid !== 1'b1 || out !== exp_out[c-1] || ones !== exp_ones[c-1] ||
            parity !== ^exp_out[c-1]) begin
          errors++;
          $display("FAIL sweep_op%0d: got valid=%b out=%h ones=%0d par=%b need 1 %h %0d %b",
                   c - 1, out_valid, out, ones, parity, exp_out[c-1], exp_ones[c-1],
                   ^exp_out[c-1]);
        end
      end
    end
    checks++;
    if (out_valid !== 1'b0 || xfer_count !== 4'd8) begin
      errors++;
      $display("FAIL sweep_end: got valid=%b cnt=%0d need 0 8", out_valid, xfer_count);
    end
  endtask

  task automatic test_backpressure();
    int k;
    int got;
    logic [7:0] held;
    do_reset();
    k = 0; got = 0; held = 8'h00;
    op = 3'd4;
    for (int c = 0; c < 14; c++) begin
      out_ready = (c >= 5);
      in_valid = (k < 4);
      x = 8'(8'h11 * (k + 1)); y = 8'h0F;
      #1;
      if (c == 0 || c == 1) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL bp_ready_early c=%0d: got %b need 1", c, in_ready);
        end
      end
      if (c >= 2 && c <= 4) begin
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out !== 8'h1E) begin
          errors++;
          $display("FAIL bp_stall c=%0d: got ready=%b valid=%b out=%h need 0 1 1e",
                   c, in_ready, out_valid, out);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL bp_extra: got out=%h need no result", out);
        end else begin
          held = exp_q.pop_front();
          if (out !== held) begin
            errors++;
            $display("FAIL bp_data %0d: got %h need %h", got, out, held);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(x ^ y);
        k++;
      end
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (got != 4 || exp_q.size() != 0 || xfer_count !== 4'd4) begin
      errors++;
      $display("FAIL bp_total: got results=%0d left=%0d cnt=%0d need 4 0 4",
               got, exp_q.size(), xfer_count);
    end
  endtask

  task automatic test_back_to_back();
    int sent;
    int got;
    int after_drop;
    logic [7:0] e;
    do_reset();
    out_ready = 1'b1;
    sent = 0; got = 0; after_drop = 0;
    for (int c = 0; c < 26; c++) begin
      in_valid = (sent < 20);
      op = 3'($urandom_range(0, 7));
      x = 8'($urandom_range(0, 255));
      y = 8'($urandom_range(0, 255));
      z = 8'($urandom_range(0, 255));
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready c=%0d: got %b need 1", c, in_ready);
      end
      if (out_valid && out_ready) begin
        checks++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : ~out;
        if (out !== e) begin
          errors++;
          $display("FAIL b2b_data %0d: got %h need %h", got, out, e);
        end
        got++;
        if (!in_valid) after_drop++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(op, x, y, z));
        sent++;
      end
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (got != 20 || after_drop != 2) begin
      errors++;
      $display("FAIL b2b_total: got results=%0d after_drop=%0d need 20 2", got, after_drop);
    end
  endtask

  task automatic test_counter_wrap();
    int n;
    do_reset();
    out_ready = 1'b1;
    op = 3'd1;
    n = 0;
    for (int c = 0; c < 19; c++) begin
      in_valid = (c < 17);
      x = 8'(c); y = 8'h80;
      #1;
      if (out_valid && out_ready) n++;
      tick();
      if (c >= 2) begin
        checks++;
        if (xfer_count !== 4'(n)) begin
          errors++;
          $display("FAIL wrap_count after %0d: got %0d need %0d", n, xfer_count, 4'(n));
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (n != 17 || xfer_count !== 4'd1) begin
      errors++;
      $display("FAIL wrap_final: got transfers=%0d cnt=%0d need 17 1", n, xfer_count);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    op = 3'd0; x = 8'hFF; y = 8'hFF;
    for (int c = 0; c < 6; c++) begin
      out_ready = (c < 3);
      in_valid = 1'b1;
      tick();
    end
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || xfer_count !== 4'd1) begin
      errors++;
      $display("FAIL mid_full: got valid=%b ready=%b cnt=%0d need 1 0 1",
               out_valid, in_ready, xfer_count);
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || xfer_count !== 4'd0 || out !== 8'h00) begin
      errors++;
      $display("FAIL mid_async: got valid=%b cnt=%0d out=%h need 0 0 00",
               out_valid, xfer_count, out);
    end
    tick();
    rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    op = 3'd6; x = 8'h00; y = 8'h00; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out !== 8'hFF || ones !== 4'd8 || parity !== 1'b0) begin
      errors++;
      $display("FAIL mid_nor: got valid=%b out=%h ones=%0d par=%b need 1 ff 8 0",
               out_valid, out, ones, parity);
    end
    tick();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 3'd0; x = '0; y = '0; z = '0;
    test_reset();
    test_basic_and();
    test_op_sweep();
    test_backpressure();
    test_back_to_back();
    test_counter_wrap();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, pipelined successor to the single-bit and2/or2/inv/gates primitives.
- Applies a selectable bitwise logic function to WIDTH-bit operands x, y, z.
- Adds valid/ready flow control, a 2-stage pipeline, result popcount/parity and a completed-transfer counter.
- Sits between a stimulus/bus source and a downstream consumer; it is the datapath building block for later logic-array work.

Parameters:
- WIDTH, 8, operand/result width in bits (1..64).
- CNT_W, 16, width of the completed-transfer counter.
- PC_W, $clog2(WIDTH+1), popcount width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and op are valid this cycle.
- in_ready  output  1  block accepts operands this cycle.
- op  input  3  function select (encoding below).
- x  input  WIDTH  operand x.
- y  input  WIDTH  operand y.
- z  input  WIDTH  operand z (used only by CIRC).
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- out  output  WIDTH  logic result.
- ones  output  PC_W  number of 1 bits in out.
- parity  output  1  XOR-reduction of out.
- xfer_count  output  CNT_W  number of completed output handshakes.

Behaviour:
- Reset is asynchronous and active-low: clk is the only clock, and rst_n low clears state immediately, independent of clk.
- Reset values:
  - out_valid=0, out=0, ones=0, parity=0, xfer_count=0.
  - Both stage valid flags are 0.
  - in_ready=1 once rst_n is high.
- op encoding, all bitwise across WIDTH:
  - 000 AND: x&y.
  - 001 OR: x|y.
  - 010 INVX: ~x.
  - 011 INVY: ~y.
  - 100 XOR: x^y.
  - 101 NAND: ~(x&y).
  - 110 NOR: ~(x|y).
  - 111 CIRC: (x&y)|~z.
- Stage 1 (S1): on an input handshake (in_valid && in_ready), register the function result and set s1_valid.
- Stage 2 (S2): on an S1→S2 advance, register out=S1 result, ones=popcount(S1 result) and parity=^S1 result, and set s2_valid. out_valid = s2_valid.
- Advance rules:
  - s2_free = !s2_valid || out_ready.
  - S1 advances into S2 when s1_valid && s2_free.
  - in_ready = !s1_valid || s2_free. This is combinational from out_ready; no combinational path exists from in_valid to in_ready.
- Latency and throughput:
  - Latency is 2 cycles: an input accepted at edge N produces out_valid=1 after edge N+1.
  - Throughput is 1 result per cycle while out_ready=1.
- Backpressure:
  - While out_valid=1 and out_ready=0, out/ones/parity hold stable.
  - S1 holds its result. in_ready drops once S1 is occupied.
  - No data is lost or duplicated.
- Simultaneous events:
  - Output handshake, S1→S2 advance and input handshake in the same cycle are all legal. All three occur, and the pipeline stays full.
  - If S2 drains and S1 is empty, s2_valid clears.
- Counter:
  - xfer_count increments by 1 on every cycle with out_valid && out_ready.
  - Wraps from 2^CNT_W-1 to 0 with no flag.
- Values on x/y/z/op when no input handshake occurs are ignored.
- Reset mid-operation: any in-flight S1/S2 data is discarded, out_valid falls asynchronously and xfer_count returns to 0. The first post-reset input follows normal latency.
- op values are never illegal; all 8 codes are defined.

Test Plan:
- Reset and basic AND:
  - Stimulus: hold rst_n=0, check outputs; release, then present WIDTH=8, op=000, x=8'hF0, y=8'h3C for 1 cycle with out_ready=1.
  - Required: under reset out_valid=0, xfer_count=0. Two cycles after acceptance out=8'h30, ones=2, parity=0, and xfer_count becomes 1.
- Op sweep:
  - Stimulus: x=8'hA5, y=8'h0F, z=8'h33, ops 000..111 back-to-back.
  - Required outputs in order: 05, AF, 5A, F0, AA, FA, 50, CD. ones = 2,6,4,4,4,6,2,5. One result per cycle.
- Backpressure:
  - Stimulus: stream 4 XOR transactions with out_ready=0 for 3 cycles, then 1.
  - Required:
    - in_ready falls after 2 accepts.
    - The first result is held stable while stalled.
    - All 4 results emerge in order with none dropped.
    - xfer_count=4.
- Simultaneous in/out:
  - Stimulus: continuous in_valid=1 and out_ready=1 for 20 cycles with random operands.
  - Required: in_ready stays 1 and exactly 20 results match the model. The last 2 of them complete after in_valid drops.
- Counter wrap:
  - Stimulus: CNT_W=4, 17 transfers.
  - Required: xfer_count sequence 1..15, 0, 1.
- Mid-operation reset:
  - Stimulus: assert rst_n=0 between clock edges with both stages full.
  - Required: out_valid=0 immediately without a clock edge, and xfer_count=0. After release, a new NOR of 8'h00,8'h00 returns out=8'hFF, ones=8, parity=0.
